// File: rtl/proc_scoreboard.sv
// rtl/proc_scoreboard.sv - per-register RAW scoreboard with latency classes, hold and flush
module proc_scoreboard #(
  parameter int NREGS   = 32,
  parameter int NSTAGES = 3,
  parameter int LD_LAT  = 2,
  parameter int MUL_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_val_D,
  input  logic                     rs1_en_D,
  input  logic [$clog2(NREGS)-1:0] rs1_D,
  input  logic                     rs2_en_D,
  input  logic [$clog2(NREGS)-1:0] rs2_D,
  input  logic                     rd_wen_D,
  input  logic [$clog2(NREGS)-1:0] rd_D,
  input  logic [1:0]               lat_sel_D,
  input  logic                     squash_D,
  input  logic                     hold,
  input  logic                     flush,
  output logic                     stall_D,
  output logic [1:0]               op1_byp_sel_D,
  output logic [1:0]               op2_byp_sel_D,
  output logic                     issue_fire,
  output logic                     busy
);

  localparam int AW = $clog2(NREGS);
  localparam int SW = $clog2(NSTAGES + 1);

  // Entry 0 is never written, so x0 always reads as not pending.
  logic          pend  [NREGS];
  logic [SW-1:0] stage [NREGS];
  logic [SW-1:0] cnt   [NREGS];

  logic          rs1_blk;
  logic          rs2_blk;
  logic [SW-1:0] issue_cnt;

  // Source 1 hazard lookup: bypass from the producer's stage once its countdown hits zero
  always_comb begin
    op1_byp_sel_D = 2'd0;
    rs1_blk       = 1'b0;
    if (issue_val_D && rs1_en_D && (rs1_D != '0) && pend[rs1_D]) begin
      if (cnt[rs1_D] == '0)
        op1_byp_sel_D = 2'({1'b0, stage[rs1_D]} + 1);
      else
        rs1_blk = 1'b1;
    end
  end

  // Source 2 hazard lookup, same rule as source 1
  always_comb begin
    op2_byp_sel_D = 2'd0;
    rs2_blk       = 1'b0;
    if (issue_val_D && rs2_en_D && (rs2_D != '0) && pend[rs2_D]) begin
      if (cnt[rs2_D] == '0)
        op2_byp_sel_D = 2'({1'b0, stage[rs2_D]} + 1);
      else
        rs2_blk = 1'b1;
    end
  end

  // Stall ignores hold so the control unit sees the hazard even while frozen
  always_comb begin
    stall_D    = issue_val_D & ~squash_D & (rs1_blk | rs2_blk);
    issue_fire = issue_val_D & ~squash_D & ~stall_D & ~hold;
  end

  // Initial countdown for a new writer: cycles until bypassable, minus one
  always_comb begin
    issue_cnt = '0;
    case (lat_sel_D)
      2'd0:    issue_cnt = '0;
      2'd1:    issue_cnt = SW'(LD_LAT - 1);
      2'd2:    issue_cnt = SW'(MUL_LAT - 1);
      default: issue_cnt = SW'(NSTAGES - 1);
    endcase
  end

  // Any pending entry keeps the pipeline non-empty
  always_comb begin
    busy = 1'b0;
    for (int r = 1; r < NREGS; r++)
      busy = busy | pend[r];
  end

  // Entry update: flush clears, a new writer takes ownership, otherwise advance one stage
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        pend[r]  <= 1'b0;
        stage[r] <= '0;
        cnt[r]   <= '0;
      end
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (flush) begin
          pend[r] <= 1'b0;
        end else if (issue_fire && rd_wen_D && (rd_D == AW'(r))) begin
          pend[r]  <= 1'b1;
          stage[r] <= '0;
          cnt[r]   <= issue_cnt;
        end else if (!hold && pend[r]) begin
          stage[r] <= stage[r] + 1'b1;
          cnt[r]   <= (cnt[r] == '0) ? '0 : cnt[r] - 1'b1;
          if (stage[r] == SW'(NSTAGES - 1))
            pend[r] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_proc_scoreboard.sv
// tb/tb_proc_scoreboard.sv - queue-scoreboard bench for proc_scoreboard
module tb_proc_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_val_D, rs1_en_D, rs2_en_D, rd_wen_D, squash_D, hold, flush;
  logic [4:0] rs1_D, rs2_D, rd_D;
  logic [1:0] lat_sel_D;
  logic       stall_D, issue_fire, busy;
  logic [1:0] op1_byp_sel_D, op2_byp_sel_D;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       rst;
    logic       val;
    logic       e1;
    logic [4:0] s1;
    logic       e2;
    logic [4:0] s2;
    logic       w;
    logic [4:0] rd;
    logic [1:0] lat;
    logic       sq;
    logic       hold;
    logic       flush;
  } stim_t;

  stim_t      stim_q[$];
  logic [6:0] exp_q[$];

  proc_scoreboard #(.NREGS(32), .NSTAGES(3), .LD_LAT(2), .MUL_LAT(3)) dut (
    .clk(clk), .rst(rst),
    .issue_val_D(issue_val_D),
    .rs1_en_D(rs1_en_D), .rs1_D(rs1_D),
    .rs2_en_D(rs2_en_D), .rs2_D(rs2_D),
    .rd_wen_D(rd_wen_D), .rd_D(rd_D),
    .lat_sel_D(lat_sel_D), .squash_D(squash_D),
    .hold(hold), .flush(flush),
    .stall_D(stall_D),
    .op1_byp_sel_D(op1_byp_sel_D), .op2_byp_sel_D(op2_byp_sel_D),
    .issue_fire(issue_fire), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(logic val, logic e1, logic [4:0] s1, logic e2, logic [4:0] s2,
                               logic w, logic [4:0] rd, logic [1:0] lat);
    stim_t s;
    s = '0;
    s.val = val; s.e1 = e1; s.s1 = s1; s.e2 = e2; s.s2 = s2;
    s.w = w; s.rd = rd; s.lat = lat;
    return s;
  endfunction

  function automatic stim_t idle();        return mk(0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic stim_t nop();         return mk(1, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic stim_t wr(logic [4:0] rd, logic [1:0] lat); return mk(1, 0, 0, 0, 0, 1, rd, lat); endfunction
  function automatic stim_t rd1(logic [4:0] s); return mk(1, 1, s, 0, 0, 0, 0, 0); endfunction
  function automatic stim_t rd2(logic [4:0] s); return mk(1, 0, 0, 1, s, 0, 0, 0); endfunction

  function automatic logic [6:0] ex(logic st, logic [1:0] s1, logic [1:0] s2, logic f, logic b);
    return {st, s1, s2, f, b};
  endfunction

  task automatic push(input stim_t s, input logic [6:0] e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic apply(input stim_t s);
    rst = s.rst; issue_val_D = s.val;
    rs1_en_D = s.e1; rs1_D = s.s1; rs2_en_D = s.e2; rs2_D = s.s2;
    rd_wen_D = s.w; rd_D = s.rd; lat_sel_D = s.lat;
    squash_D = s.sq; hold = s.hold; flush = s.flush;
  endtask

  task automatic do_reset();
    stim_t s;
    s = idle(); s.rst = 1'b1;
    apply(s);
    @(posedge clk); #1;
    apply(idle());
  endtask

  task automatic test_reset();
    stim_t s;
    logic [6:0] e, got;
    int i = 0;
    // dirty inputs during reset must not leave an entry behind
    s = wr(5'd9, 2'd1); s.rst = 1'b1;
    push(s,             ex(0, 0, 0, 1, 0));
    push(idle(),        ex(0, 0, 0, 0, 0));
    push(rd1(5'd9),     ex(0, 0, 0, 1, 0));
    push(wr(5'd5, 0),   ex(0, 0, 0, 1, 0));
    push(idle(),        ex(0, 0, 0, 0, 1));
    push(idle(),        ex(0, 0, 0, 0, 1));
    push(idle(),        ex(0, 0, 0, 0, 1));
    push(idle(),        ex(0, 0, 0, 0, 0));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      got = {stall_D, op1_byp_sel_D, op2_byp_sel_D, issue_fire, busy};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL reset step %0d: got %b expected %b", i, got, e);
      end
      i++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu_chain();
    logic [6:0] e, got;
    logic [1:0] sel;
    for (int gap = 0; gap < 4; gap++) begin
      int i = 0;
      do_reset();
      sel = (gap < 3) ? 2'(gap + 1) : 2'd0;
      push(wr(5'd5, 0), ex(0, 0, 0, 1, 0));
      for (int k = 0; k < gap; k++) push(nop(), ex(0, 0, 0, 1, 1));
      push(rd1(5'd5), ex(0, sel, 0, 1, gap < 3));
      while (stim_q.size() > 0) begin
        apply(stim_q.pop_front());
        @(negedge clk);
        e = exp_q.pop_front();
        got = {stall_D, op1_byp_sel_D, op2_byp_sel_D, issue_fire, busy};
        n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL alu_chain gap %0d step %0d: got %b expected %b", gap, i, got, e);
        end
        i++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_load_use();
    stim_t s;
    logic [6:0] e, got;
    int i = 0;
    do_reset();
    s = mk(1, 0, 0, 1, 5'd3, 1, 5'd8, 0);
    push(wr(5'd3, 1), ex(0, 0, 0, 1, 0));
    push(s,           ex(1, 0, 0, 0, 1));
    push(s,           ex(0, 0, 2, 1, 1));
    push(rd1(5'd8),   ex(0, 1, 0, 1, 1));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      got = {stall_D, op1_byp_sel_D, op2_byp_sel_D, issue_fire, busy};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL load_use step %0d: got %b expected %b", i, got, e);
      end
      i++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mul_x0();
    stim_t s;
    logic [6:0] e, got;
    int i = 0;
    do_reset();
    push(wr(5'd7, 2), ex(0, 0, 0, 1, 0));
    push(rd1(5'd7),   ex(1, 0, 0, 0, 1));
    push(rd1(5'd7),   ex(1, 0, 0, 0, 1));
    push(rd1(5'd7),   ex(0, 3, 0, 1, 1));
    push(wr(5'd0, 2), ex(0, 0, 0, 1, 0));
    s = mk(1, 1, 0, 1, 0, 0, 0, 0);
    push(s,           ex(0, 0, 0, 1, 0));
    push(wr(5'd10, 3), ex(0, 0, 0, 1, 0));
    push(rd2(5'd10),   ex(1, 0, 0, 0, 1));
    push(rd2(5'd10),   ex(1, 0, 0, 0, 1));
    push(rd2(5'd10),   ex(0, 0, 3, 1, 1));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      got = {stall_D, op1_byp_sel_D, op2_byp_sel_D, issue_fire, busy};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL mul_x0 step %0d: got %b expected %b", i, got, e);
      end
      i++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_waw_squash();
    stim_t s;
    logic [6:0] e, got;
    int i = 0;
    do_reset();
    push(wr(5'd4, 1), ex(0, 0, 0, 1, 0));
    push(wr(5'd4, 0), ex(0, 0, 0, 1, 1));
    push(rd1(5'd4),   ex(0, 1, 0, 1, 1));
    push(idle(),      ex(0, 0, 0, 0, 1));
    push(idle(),      ex(0, 0, 0, 0, 1));
    push(idle(),      ex(0, 0, 0, 0, 0));
    s = wr(5'd11, 0); s.sq = 1'b1;
    push(s,           ex(0, 0, 0, 0, 0));
    push(rd1(5'd11),  ex(0, 0, 0, 1, 0));
    push(wr(5'd12, 1), ex(0, 0, 0, 1, 0));
    s = rd1(5'd12); s.sq = 1'b1;
    push(s,           ex(0, 0, 0, 0, 1));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      got = {stall_D, op1_byp_sel_D, op2_byp_sel_D, issue_fire, busy};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL waw_squash step %0d: got %b expected %b", i, got, e);
      end
      i++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_hold();
    stim_t s;
    logic [6:0] e, got;
    int i = 0;
    do_reset();
    push(wr(5'd6, 1), ex(0, 0, 0, 1, 0));
    s = rd1(5'd6); s.hold = 1'b1;
    for (int k = 0; k < 3; k++) push(s, ex(1, 0, 0, 0, 1));
    push(rd1(5'd6),   ex(1, 0, 0, 0, 1));
    push(rd1(5'd6),   ex(0, 2, 0, 1, 1));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      got = {stall_D, op1_byp_sel_D, op2_byp_sel_D, issue_fire, busy};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL hold step %0d: got %b expected %b", i, got, e);
      end
      i++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush_rst();
    stim_t s;
    logic [6:0] e, got;
    for (int use_rst = 0; use_rst < 2; use_rst++) begin
      int i = 0;
      do_reset();
      push(wr(5'd1, 0), ex(0, 0, 0, 1, 0));
      push(wr(5'd2, 0), ex(0, 0, 0, 1, 1));
      push(wr(5'd3, 0), ex(0, 0, 0, 1, 1));
      s = mk(1, 1, 5'd1, 1, 5'd2, 1, 5'd4, 0);
      if (use_rst != 0) s.rst = 1'b1; else s.flush = 1'b1;
      push(s,           ex(0, 3, 2, 1, 1));
      push(mk(1, 1, 5'd3, 1, 5'd4, 0, 0, 0), ex(0, 0, 0, 1, 0));
      while (stim_q.size() > 0) begin
        apply(stim_q.pop_front());
        @(negedge clk);
        e = exp_q.pop_front();
        got = {stall_D, op1_byp_sel_D, op2_byp_sel_D, issue_fire, busy};
        n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL flush_rst mode %0d step %0d: got %b expected %b", use_rst, i, got, e);
        end
        i++;
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    apply(idle());
    rst = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_alu_chain();
    test_load_use();
    test_mul_x0();
    test_waw_squash();
    test_hold();
    test_flush_rst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
